// File: rtl/pcileech_cfg_func_arbiter.sv
// Round-robin arbiter sharing one multi-function config-space port.
// One access in flight: accept -> memory access -> completion handshake.
`timescale 1ns/1ps

module pcileech_cfg_func_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk_pcie,
    input  logic                    rst_n,
    input  logic [7:0]              func_mask,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [NUM_REQ*10-1:0]   req_addr,
    input  logic [NUM_REQ*4-1:0]    req_be,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    input  logic [NUM_REQ*8-1:0]    req_tag,
    input  logic [NUM_REQ*16-1:0]   req_reqid,
    output logic                    mem_en,
    output logic                    mem_wr,
    output logic [2:0]              mem_func,
    output logic [9:0]              mem_addr,
    output logic [3:0]              mem_be,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [2:0]              cpl_func,
    output logic                    cpl_tlpwr,
    output logic [2:0]              cpl_status,
    output logic [7:0]              cpl_tag,
    output logic [15:0]             cpl_reqid,
    output logic [31:0]             cpl_data,
    output logic [15:0]             ur_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);
    localparam logic [3:0] NREQ4    = 4'(NUM_REQ);

    state_t      state;
    state_t      state_nx;

    logic [2:0]  rr_ptr;
    logic [2:0]  win;
    logic [2:0]  win_nx;
    logic        found;
    logic [3:0]  scan;

    logic [2:0]  func_q;
    logic        wr_q;
    logic [9:0]  addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  tag_q;
    logic [15:0] reqid_q;
    logic [31:0] data_q;
    logic        ur_q;
    logic [1:0]  lat_cnt;

    // Scan upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + 4'(k);
            if (scan >= NREQ4)
                scan = scan - NREQ4;
            if (!found && req_valid[scan[2:0]]) begin
                found = 1'b1;
                win   = scan[2:0];
            end
        end
    end

    assign win_nx = (int'(win) == NUM_REQ - 1) ? 3'd0 : win + 3'd1;

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (found)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                if (!func_mask[func_q] || wr_q)
                    state_nx = RESP;
                else
                    state_nx = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 2'd0)
                    state_nx = RESP;
            end
            RESP: begin
                if (cpl_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            func_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            tag_q    <= '0;
            reqid_q  <= '0;
            data_q   <= '0;
            ur_q     <= 1'b0;
            lat_cnt  <= '0;
            ur_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        rr_ptr  <= win_nx;
                        func_q  <= win;
                        wr_q    <= req_wr[win];
                        addr_q  <= req_addr[10*win +: 10];
                        be_q    <= req_be[4*win +: 4];
                        wdata_q <= req_wdata[32*win +: 32];
                        tag_q   <= req_tag[8*win +: 8];
                        reqid_q <= req_reqid[16*win +: 16];
                    end
                end
                ISSUE: begin
                    ur_q   <= ~func_mask[func_q];
                    data_q <= '0;
                    if (func_mask[func_q] && !wr_q)
                        lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0)
                        data_q <= mem_rdata;
                    else
                        lat_cnt <= lat_cnt - 2'd1;
                end
                RESP: begin
                    if (cpl_ready && ur_q && ur_count != 16'hFFFF)
                        ur_count <= ur_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // mem_* and cpl_* are forced to zero outside their active states.
    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_func   = '0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        cpl_valid  = 1'b0;
        cpl_func   = '0;
        cpl_tlpwr  = 1'b0;
        cpl_status = '0;
        cpl_tag    = '0;
        cpl_reqid  = '0;
        cpl_data   = '0;
        if (state == ISSUE && func_mask[func_q]) begin
            mem_en    = 1'b1;
            mem_wr    = wr_q;
            mem_func  = func_q;
            mem_addr  = addr_q;
            mem_be    = be_q;
            mem_wdata = wr_q ? wdata_q : 32'd0;
        end
        if (state == RESP) begin
            cpl_valid  = 1'b1;
            cpl_func   = func_q;
            cpl_tlpwr  = wr_q;
            cpl_status = {2'b00, ur_q};
            cpl_tag    = tag_q;
            cpl_reqid  = reqid_q;
            cpl_data   = data_q;
        end
    end

endmodule

// File: tb/tb_pcileech_cfg_func_arbiter.sv
// Scoreboard bench for pcileech_cfg_func_arbiter.
// Accepts push expected completions; handshakes pop and compare.
`timescale 1ns/1ps

module tb_pcileech_cfg_func_arbiter;

    localparam int NR  = 8;
    localparam int RDL = 2;

    logic              clk_pcie = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        func_mask;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_wr;
    logic [NR*10-1:0]  req_addr;
    logic [NR*4-1:0]   req_be;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*8-1:0]   req_tag;
    logic [NR*16-1:0]  req_reqid;
    logic              mem_en;
    logic              mem_wr;
    logic [2:0]        mem_func;
    logic [9:0]        mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cpl_valid;
    logic              cpl_ready;
    logic [2:0]        cpl_func;
    logic              cpl_tlpwr;
    logic [2:0]        cpl_status;
    logic [7:0]        cpl_tag;
    logic [15:0]       cpl_reqid;
    logic [31:0]       cpl_data;
    logic [15:0]       ur_count;

    always #5 clk_pcie = ~clk_pcie;

    pcileech_cfg_func_arbiter #(.NUM_REQ(NR), .RD_LATENCY(RDL)) dut (
        .clk_pcie(clk_pcie), .rst_n(rst_n), .func_mask(func_mask),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .req_tag(req_tag), .req_reqid(req_reqid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_func(mem_func),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_func(cpl_func),
        .cpl_tlpwr(cpl_tlpwr), .cpl_status(cpl_status), .cpl_tag(cpl_tag),
        .cpl_reqid(cpl_reqid), .cpl_data(cpl_data), .ur_count(ur_count)
    );

    typedef struct {
        logic [2:0]  func;
        logic        wr;
        logic        ur;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  tag;
        logic [15:0] reqid;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          tb_ptr = 0;
    int          exp_ur = 0;
    int          src_cnt[NR];
    logic [NR-1:0] acc_flag = '0;
    int          bp_left = 0;
    bit          rnd_rdy = 0;
    bit          prev_valid = 0;
    bit          prev_hs = 0;
    logic [62:0] snap = '0;
    bit          pv[4];
    logic [31:0] pd[4];

    function automatic logic [31:0] memval(logic [2:0] f, logic [9:0] a);
        if (f == 3'd0 && a == 10'h004)
            return 32'hDEADBEEF;
        return {8'hA5, 5'd0, f, 6'd0, a};
    endfunction

    // Config memory: read data valid only RDL cycles after mem_en.
    always @(posedge clk_pcie) begin
        pv[0] <= mem_en && !mem_wr;
        pd[0] <= memval(mem_func, mem_addr);
        for (int k = 1; k < 4; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign mem_rdata = pv[RDL-1] ? pd[RDL-1] : 32'hBAD0BAD0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_req(int i, bit wr, logic [9:0] a, logic [3:0] be,
                           logic [31:0] wd, logic [7:0] tg, logic [15:0] rid);
        req_wr[i]            = wr;
        req_addr[i*10 +: 10] = a;
        req_be[i*4 +: 4]     = be;
        req_wdata[i*32 +: 32]= wd;
        req_tag[i*8 +: 8]    = tg;
        req_reqid[i*16 +: 16]= rid;
        req_valid[i]         = 1'b1;
    endtask

    task automatic rand_req(int i);
        set_req(i, 1'($urandom), 10'($urandom), 4'($urandom),
                $urandom, 8'($urandom), 16'($urandom));
    endtask

    task automatic monitor();
        logic [62:0] cb;
        exp_t        e;
        int          g;
        int          w;
        cb = {cpl_func, cpl_tlpwr, cpl_status, cpl_tag, cpl_reqid, cpl_data};
        check("onehot", 64'($countones(req_ready) <= 1), 1);
        check("ur_count", ur_count, 64'(exp_ur));
        if (prev_hs)
            check("cpl_drop", cpl_valid, 0);
        if (cpl_valid) begin
            if (!prev_valid) begin
                check("cpl_pending", 64'(sb.size() > 0), 1);
                if (sb.size() > 0)
                    check("cpl_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end else if (!prev_hs) begin
                check("cpl_stable", cb, snap);
            end
            snap = cb;
            if (cpl_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("cpl_fields", cb, {e.func, e.wr, e.ur ? 3'b001 : 3'b000,
                                         e.tag, e.reqid, e.data});
                if (e.ur && exp_ur < 65535)
                    exp_ur++;
            end
        end
        prev_valid = cpl_valid;
        prev_hs    = cpl_valid && cpl_ready;
        if (mem_en) begin
            check("mem_outstanding", 64'(sb.size()), 1);
            check("mem_fn_enabled", func_mask[mem_func], 1);
            if (sb.size() > 0) begin
                e = sb[0];
                check("mem_cycle", 64'(cyc), 64'(e.acc + 1));
                check("mem_bus", {mem_wr, mem_func, mem_addr, mem_be},
                      {e.wr, e.func, e.addr, e.be});
                if (e.wr)
                    check("mem_wdata", mem_wdata, e.wdata);
            end
        end else begin
            check("mem_idle", {mem_wr, mem_func, mem_addr, mem_be, mem_wdata}, 0);
        end
        if (req_ready != '0) begin
            g = 0;
            for (int i = 0; i < NR; i++)
                if (req_ready[i]) g = i;
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && req_valid[(tb_ptr + k) % NR]) w = (tb_ptr + k) % NR;
            check("grant", 64'(g), 64'(w));
            check("accept_idle", 64'(sb.size()), 0);
            e.func  = 3'(g);
            e.wr    = req_wr[g];
            e.ur    = !func_mask[g];
            e.addr  = req_addr[g*10 +: 10];
            e.be    = req_be[g*4 +: 4];
            e.wdata = req_wdata[g*32 +: 32];
            e.tag   = req_tag[g*8 +: 8];
            e.reqid = req_reqid[g*16 +: 16];
            e.data  = (e.ur || e.wr) ? 32'd0 : memval(e.func, e.addr);
            e.acc   = cyc;
            e.lat   = (e.ur || e.wr) ? 2 : 2 + RDL;
            sb.push_back(e);
            acc_flag[g] = 1'b1;
            tb_ptr = (g + 1) % NR;
            grant_log.push_back(g);
        end
    endtask

    task automatic update();
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                src_cnt[i]--;
                if (src_cnt[i] > 0)
                    rand_req(i);
                else
                    req_valid[i] = 1'b0;
            end
        end
        if (bp_left > 0 && cpl_valid) begin
            cpl_ready = 1'b0;
            bp_left--;
        end else begin
            cpl_ready = rnd_rdy ? 1'($urandom) : 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk_pcie);
        monitor();
        @(posedge clk_pcie);
        cyc++;
        #1;
        update();
    endtask

    task automatic run_until_idle(int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("timeout", 64'(n < budget), 1);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[6];
        order = '{0, 1, 3, 0, 1, 3};
        func_mask = '0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        req_tag   = '0;
        req_reqid = '0;
        cpl_ready = 1'b1;
        for (int i = 0; i < NR; i++) src_cnt[i] = 0;
        repeat (3) @(posedge clk_pcie);
        #1;
        check("reset_outs", {req_ready, mem_en, cpl_valid, cpl_status,
                             cpl_data, ur_count}, 0);
        rst_n = 1'b1;

        // Round robin among 0, 1, 3
        func_mask = 8'hFF;
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                src_cnt[i] = 2;
                rand_req(i);
            end
        end
        run_until_idle(200);
        check("rr_count", 64'(grant_log.size()), 6);
        for (int k = 0; k < 6; k++)
            if (k < grant_log.size())
                check("rr_order", 64'(grant_log[k]), 64'(order[k]));

        // Single read from function 0
        func_mask = 8'h01;
        src_cnt[0] = 1;
        set_req(0, 1'b0, 10'h004, 4'hF, 32'd0, 8'h11, 16'h0100);
        run_until_idle(50);

        // Disabled function gets UR
        src_cnt[2] = 1;
        set_req(2, 1'b0, 10'h010, 4'hF, 32'd0, 8'h22, 16'h0200);
        run_until_idle(50);
        check("ur_after", ur_count, 1);

        // Write path
        func_mask = 8'hFF;
        src_cnt[1] = 1;
        set_req(1, 1'b1, 10'h001, 4'hF, 32'h00000146, 8'h33, 16'h0300);
        run_until_idle(50);

        // Backpressure plus a request withdrawn before grant
        bp_left = 10;
        src_cnt[0] = 1;
        src_cnt[1] = 1;
        rand_req(0);
        rand_req(1);
        tick();
        src_cnt[5] = 1;
        rand_req(5);
        repeat (3) tick();
        req_valid[5] = 1'b0;
        src_cnt[5] = 0;
        run_until_idle(100);

        // Random traffic with random mask and completion stalls
        rnd_rdy = 1;
        for (int b = 0; b < 6; b++) begin
            func_mask = 8'($urandom);
            for (int i = 0; i < NR; i++) begin
                src_cnt[i] = $urandom_range(0, 3);
                if (src_cnt[i] > 0) rand_req(i);
            end
            run_until_idle(2000);
        end
        rnd_rdy = 0;

        // Reset during WAIT
        func_mask = 8'hFF;
        src_cnt[3] = 1;
        set_req(3, 1'b0, 10'h020, 4'hF, 32'd0, 8'h44, 16'h0400);
        for (int n = 0; n < 20 && sb.size() == 0; n++) tick();
        check("rst_test_accept", 64'(sb.size()), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {req_ready, mem_en, cpl_valid, cpl_data,
                                   cpl_tag, ur_count}, 0);
        sb.delete();
        grant_log.delete();
        tb_ptr     = 0;
        exp_ur     = 0;
        acc_flag   = '0;
        req_valid  = '0;
        prev_valid = 0;
        prev_hs    = 0;
        for (int i = 0; i < NR; i++) src_cnt[i] = 0;
        repeat (2) @(posedge clk_pcie);
        #1;
        rst_n = 1'b1;
        src_cnt[6] = 1;
        src_cnt[2] = 1;
        rand_req(6);
        rand_req(2);
        run_until_idle(100);
        check("post_reset_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
